count_monitor: RTL

Passive checker on the receiving end of the up-counter interface: samples `enable` and `count` every clock and predicts the next count. It flags any deviation, counts errors and wrap-arounds, and escalates to a sticky fault after repeated consecutive mismatches. It sits beside the counter in simulation and on-chip self-test, and never drives the counter.

---
 rtl/count_monitor.sv | 135 +++++++++++++
 1 files changed

// File: rtl/count_monitor.sv
// Passive checker for an up-counter: predicts the next count from enable/count,
// flags and counts deviations and wraps, and latches a fault on repeated errors.
module count_monitor #(
  parameter int WIDTH       = 4,
  parameter int ERR_W       = 8,
  parameter int WRAP_W      = 8,
  parameter int FAULT_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [WIDTH-1:0]  count,
  input  logic              clear,
  output logic [WIDTH-1:0]  expected,
  output logic              mismatch,
  output logic              wrap,
  output logic              fault,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WRAP_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [3:0]       LIMIT   = 4'(FAULT_LIMIT);

  state_t            state, state_n;
  logic [WIDTH-1:0]  expected_n;
  logic              mismatch_n, wrap_n, fault_n;
  logic [ERR_W-1:0]  err_cnt_n;
  logic [WRAP_W-1:0] wrap_cnt_n;
  logic [3:0]        consec, consec_n, consec_inc;
  logic [WIDTH-1:0]  prev_count;
  logic              prev_enable;
  logic [WIDTH-1:0]  prediction;
  logic [ERR_W-1:0]  err_sat_inc;

  assign prediction  = enable ? count + WIDTH'(1) : count;
  assign err_sat_inc = (err_cnt == '1) ? err_cnt : err_cnt + ERR_W'(1);
  assign consec_inc  = consec + 4'd1;

  // NOTE: every variable gets a default at the top of always_comb so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n    = state;
    expected_n = prediction;
    mismatch_n = 1'b0;
    wrap_n     = 1'b0;
    fault_n    = fault;
    err_cnt_n  = err_cnt;
    wrap_cnt_n = wrap_cnt;
    consec_n   = consec;

    if (clear) begin
      state_n    = IDLE;
      fault_n    = 1'b0;
      err_cnt_n  = '0;
      wrap_cnt_n = '0;
      consec_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          // The counter must come out of reset at zero.
          state_n  = TRACK;
          consec_n = '0;
          if (count != '0) begin
            mismatch_n = 1'b1;
            err_cnt_n  = err_sat_inc;
          end
        end
        TRACK: begin
          if (count == expected) begin
            consec_n = '0;
            if (prev_enable && (prev_count == CNT_MAX) && (count == '0)) begin
              wrap_n     = 1'b1;
              wrap_cnt_n = wrap_cnt + WRAP_W'(1);
            end
          end else begin
            // Prediction is rebuilt from the observed count, so one glitch
            // costs exactly one error rather than a cascade.
            mismatch_n = 1'b1;
            err_cnt_n  = err_sat_inc;
            consec_n   = consec_inc;
            if (consec_inc >= LIMIT) begin
              state_n = FAULT;
              fault_n = 1'b1;
            end
          end
        end
        FAULT: begin
          fault_n = 1'b1;
        end
        default: begin
          state_n = IDLE;
          fault_n = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: reset clears every register here; there is no memory array whose
  // contents would be left unreset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      expected    <= '0;
      mismatch    <= 1'b0;
      wrap        <= 1'b0;
      fault       <= 1'b0;
      err_cnt     <= '0;
      wrap_cnt    <= '0;
      consec      <= '0;
      prev_count  <= '0;
      prev_enable <= 1'b0;
    end else begin
      state       <= state_n;
      expected    <= expected_n;
      mismatch    <= mismatch_n;
      wrap        <= wrap_n;
      fault       <= fault_n;
      err_cnt     <= err_cnt_n;
      wrap_cnt    <= wrap_cnt_n;
      consec      <= consec_n;
      prev_count  <= count;
      prev_enable <= enable;
    end
  end

endmodule
